seg7_axil_slave: RTL and testbench

SEG7_AXIL_SLAVE -- requirements
Module: seg7_axil_slave

---
 rtl/seg7_pkg.sv | 66 ++++++
 rtl/seg7_axil_slave_if.sv | 33 +++
 rtl/seg7_hex_decoder.sv | 14 +
 rtl/seg7_axil_slave.sv | 213 +++++++++++++++++++++
 tb/tb_seg7_axil_slave.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the AXI4-Lite seven-segment display controller:
// register map, CTRL bit positions, bus FSM state types and the glyph table.
package seg7_pkg;

    localparam int AXI_DATA_W = 32;
    localparam int AXI_ADDR_W = 4;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    // Byte offsets of the four word registers
    localparam logic [3:0] OFF_DIGITS   = 4'h0;
    localparam logic [3:0] OFF_CTRL     = 4'h4;
    localparam logic [3:0] OFF_PRESCALE = 4'h8;
    localparam logic [3:0] OFF_BLANK    = 4'hC;

    // Word indices (address bits [3:2]) of the same registers
    localparam logic [1:0] REG_DIGITS   = OFF_DIGITS[3:2];
    localparam logic [1:0] REG_CTRL     = OFF_CTRL[3:2];
    localparam logic [1:0] REG_PRESCALE = OFF_PRESCALE[3:2];
    localparam logic [1:0] REG_BLANK    = OFF_BLANK[3:2];

    // CTRL fields
    localparam int CTRL_DP_LSB = 0;
    localparam int CTRL_EN_BIT = 8;

    localparam int PRESCALE_W = 16;
    localparam int NUM_DIGITS = 4;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}; entry 15 listed first
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_ACK  = 2'd1,
        WR_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ACK  = 2'd1,
        RD_DATA = 2'd2
    } rd_state_t;

    // Merge write data into an existing word, byte lane by byte lane
    function automatic logic [AXI_DATA_W-1:0] apply_strb(
        input logic [AXI_DATA_W-1:0] old_word,
        input logic [AXI_DATA_W-1:0] new_word,
        input logic [AXI_STRB_W-1:0] strb
    );
        logic [AXI_DATA_W-1:0] result;
        result = old_word;
        for (int b = 0; b < AXI_STRB_W; b++) begin
            if (strb[b]) begin
                result[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/seg7_axil_slave_if.sv
// AXI4-Lite bus bundle between a master and the display controller.
interface seg7_axil_slave_if;
    import seg7_pkg::*;

    logic [AXI_ADDR_W-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [AXI_ADDR_W-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    // Direct table lookup, no state
    always_comb begin
        glyph = GLYPH_TABLE[nibble];
    end

endmodule

// File: rtl/seg7_axil_slave.sv
// AXI4-Lite slave with four control registers driving a multiplexed
// four-digit seven-segment display.
module seg7_axil_slave
    import seg7_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic              s00_axi_aclk,
    input  logic              s00_axi_areset,
    seg7_axil_slave_if.slave  s00_axi,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [3:0]        an
);

    logic clk;
    logic srst;
    assign clk  = s00_axi_aclk;
    assign srst = s00_axi_areset;

    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_w;
    logic [C_S_AXI_ADDR_WIDTH-1:0] araddr_w;
    assign awaddr_w = s00_axi.awaddr;
    assign araddr_w = s00_axi.araddr;

    // Only word addressing matters; byte offset bits are ignored
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, awaddr_w[1:0], araddr_w[1:0]};

    logic [C_S_AXI_DATA_WIDTH-1:0] regs_reg [NUM_DIGITS];
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_reg;

    wr_state_t wr_state_reg, wr_state_next;
    rd_state_t rd_state_reg, rd_state_next;

    logic wr_ready, bvalid;
    logic rd_ready, rvalid;
    logic wr_fire, rd_fire;
    logic [1:0] wr_idx, rd_idx;

    assign wr_idx  = awaddr_w[3:2];
    assign rd_idx  = araddr_w[3:2];
    assign wr_fire = wr_ready & s00_axi.awvalid & s00_axi.wvalid;
    assign rd_fire = rd_ready & s00_axi.arvalid;

    // ---------------- write channel FSM ----------------

    // Write FSM state register
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_state_reg <= WR_IDLE;
        end else begin
            wr_state_reg <= wr_state_next;
        end
    end

    // Write FSM next state: accept only when address and data arrive together
    always_comb begin
        wr_state_next = wr_state_reg;
        case (wr_state_reg)
            WR_IDLE: if (s00_axi.awvalid && s00_axi.wvalid) wr_state_next = WR_ACK;
            WR_ACK:  wr_state_next = (s00_axi.awvalid && s00_axi.wvalid) ? WR_RESP : WR_IDLE;
            WR_RESP: if (s00_axi.bready) wr_state_next = WR_IDLE;
            default: wr_state_next = WR_IDLE;
        endcase
    end

    // Write FSM outputs: one-cycle ready pulse, then response held until bready
    always_comb begin
        wr_ready = (wr_state_reg == WR_ACK);
        bvalid   = (wr_state_reg == WR_RESP);
    end

    // ---------------- read channel FSM ----------------

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_state_reg <= RD_IDLE;
        end else begin
            rd_state_reg <= rd_state_next;
        end
    end

    // Read FSM next state
    always_comb begin
        rd_state_next = rd_state_reg;
        case (rd_state_reg)
            RD_IDLE: if (s00_axi.arvalid) rd_state_next = RD_ACK;
            RD_ACK:  rd_state_next = s00_axi.arvalid ? RD_DATA : RD_IDLE;
            RD_DATA: if (s00_axi.rready) rd_state_next = RD_IDLE;
            default: rd_state_next = RD_IDLE;
        endcase
    end

    // Read FSM outputs
    always_comb begin
        rd_ready = (rd_state_reg == RD_ACK);
        rvalid   = (rd_state_reg == RD_DATA);
    end

    assign s00_axi.awready = wr_ready;
    assign s00_axi.wready  = wr_ready;
    assign s00_axi.bvalid  = bvalid;
    assign s00_axi.bresp   = RESP_OKAY;
    assign s00_axi.arready = rd_ready;
    assign s00_axi.rvalid  = rvalid;
    assign s00_axi.rresp   = RESP_OKAY;
    assign s00_axi.rdata   = rdata_reg;

    // Register file update on the write handshake edge, byte-lane masked
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_fire) begin
            regs_reg[wr_idx] <= apply_strb(regs_reg[wr_idx], s00_axi.wdata, s00_axi.wstrb);
        end
    end

    // Read data captured on the address handshake; sees pre-write contents
    always_ff @(posedge clk) begin
        if (srst) begin
            rdata_reg <= '0;
        end else if (rd_fire) begin
            rdata_reg <= regs_reg[rd_idx];
        end
    end

    // ---------------- display scanning ----------------

    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] count_reg;
    logic [1:0]            idx_reg;
    logic                  ctrl_en;
    logic [3:0]            ctrl_dp;
    logic [3:0]            blank;

    assign prescale = regs_reg[REG_PRESCALE][PRESCALE_W-1:0];
    assign ctrl_en  = regs_reg[REG_CTRL][CTRL_EN_BIT];
    assign ctrl_dp  = regs_reg[REG_CTRL][CTRL_DP_LSB +: NUM_DIGITS];
    assign blank    = regs_reg[REG_BLANK][NUM_DIGITS-1:0];

    // Scan divider; a shrunken PRESCALE restarts the count without advancing
    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
            idx_reg   <= '0;
        end else if (count_reg == prescale) begin
            count_reg <= '0;
            idx_reg   <= idx_reg + 2'd1;
        end else if (count_reg > prescale) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

    logic [3:0] digit_nibble;
    logic [6:0] glyph;
    logic [3:0] an_next;
    logic       dp_next;

    // Pick the nibble of the digit currently being scanned
    always_comb begin
        digit_nibble = regs_reg[REG_DIGITS][3:0];
        case (idx_reg)
            2'd0: digit_nibble = regs_reg[REG_DIGITS][3:0];
            2'd1: digit_nibble = regs_reg[REG_DIGITS][7:4];
            2'd2: digit_nibble = regs_reg[REG_DIGITS][11:8];
            2'd3: digit_nibble = regs_reg[REG_DIGITS][15:12];
            default: digit_nibble = regs_reg[REG_DIGITS][3:0];
        endcase
    end

    seg7_hex_decoder u_hex_decoder (
        .nibble (digit_nibble),
        .glyph  (glyph)
    );

    // Anode select: active digit driven low only if enabled and not blanked
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
            assign an_next[gi] = ~(ctrl_en && !blank[gi] && (idx_reg == 2'(gi)));
        end
    endgenerate

    assign dp_next = ~ctrl_dp[idx_reg];

    logic [6:0] seg_reg;
    logic       dp_reg;
    logic [3:0] an_reg;

    // Registered display drive so pins only move on clock edges
    always_ff @(posedge clk) begin
        if (srst) begin
            seg_reg <= 7'h7F;
            dp_reg  <= 1'b1;
            an_reg  <= 4'hF;
        end else begin
            seg_reg <= glyph;
            dp_reg  <= dp_next;
            an_reg  <= an_next;
        end
    end

    assign seg = seg_reg;
    assign dp  = dp_reg;
    assign an  = an_reg;

endmodule

// File: tb/tb_seg7_axil_slave.sv
// Directed self-checking bench for the AXI4-Lite seven-segment controller.
module tb_seg7_axil_slave;

    logic       clk = 1'b0;
    logic       srst = 1'b1;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] exp_an  [4];
    logic [6:0] exp_seg [4];
    logic       exp_dp  [4];

    seg7_axil_slave_if bus ();

    seg7_axil_slave dut (
        .s00_axi_aclk   (clk),
        .s00_axi_areset (srst),
        .s00_axi        (bus),
        .seg            (seg),
        .dp             (dp),
        .an             (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int t;
        @(negedge clk);
        bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        t = 0;
        while (!bus.awready && t < 20) begin @(negedge clk); t++; end
        check("wr_awready", bus.awready, 1);
        check("wr_wready", bus.wready, 1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge clk);
        t = 0;
        while (!bus.bvalid && t < 20) begin @(negedge clk); t++; end
        check("wr_bvalid", bus.bvalid, 1);
        check("wr_bresp", bus.bresp, 0);
        $display("write addr=0x%0h data=0x%08h strb=%b", addr, data, strb);
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        int t;
        @(negedge clk);
        bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b0;
        t = 0;
        while (!bus.arready && t < 20) begin @(negedge clk); t++; end
        check("rd_arready", bus.arready, 1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        @(negedge clk);
        t = 0;
        while (!bus.rvalid && t < 20) begin @(negedge clk); t++; end
        check("rd_rvalid", bus.rvalid, 1);
        check("rd_rresp", bus.rresp, 0);
        data = bus.rdata;
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
        $display("read  addr=0x%0h data=0x%08h", addr, data);
    endtask

    // Return at the first cycle of a slot showing the given anode pattern
    task automatic wait_slot_start(input logic [3:0] target);
        int t = 0;
        @(negedge clk);
        while (an == target && t < 40) begin @(negedge clk); t++; end
        while (an != target && t < 80) begin @(negedge clk); t++; end
        check("slot_sync", an, target);
    endtask

    // Walk one full scan round against exp_* tables, len cycles per slot
    task automatic scan_round(input int len);
        for (int s = 0; s < 4; s++) begin
            check($sformatf("an_slot%0d", s), an, exp_an[s]);
            check($sformatf("seg_slot%0d", s), seg, exp_seg[s]);
            check($sformatf("dp_slot%0d", s), dp, exp_dp[s]);
            if (len > 1) begin
                repeat (len - 1) @(negedge clk);
                check($sformatf("an_slot%0d_end", s), an, exp_an[s]);
            end
            @(negedge clk);
        end
        check("an_wrap", an, exp_an[0]);
        $display("scan round len=%0d done", len);
    endtask

    initial begin : stim
        logic [31:0] rd;
        int t;

        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0;
        bus.arvalid = 1'b0; bus.rready = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", bus.awready, 0);
        check("rst_wready", bus.wready, 0);
        check("rst_arready", bus.arready, 0);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1);
        srst = 1'b0;
        $display("reset released");

        // Basic write/readback of all four registers
        axi_write(4'h0, 32'h1, 4'hF);
        axi_write(4'h4, 32'h2, 4'hF);
        axi_write(4'h8, 32'h3, 4'hF);
        axi_write(4'hC, 32'h4, 4'hF);
        axi_read(4'h0, rd); check("rb_digits", rd, 32'h1);
        axi_read(4'h4, rd); check("rb_ctrl", rd, 32'h2);
        axi_read(4'h8, rd); check("rb_prescale", rd, 32'h3);
        axi_read(4'hC, rd); check("rb_blank", rd, 32'h4);

        // Byte strobes
        axi_write(4'h0, 32'h0, 4'hF);
        axi_write(4'h0, 32'hFFFF_FFFF, 4'b0010);
        axi_read(4'h0, rd); check("strb_0010", rd, 32'h0000_FF00);
        axi_write(4'h0, 32'hAABB_CCDD, 4'b1001);
        axi_read(4'h0, rd); check("strb_1001", rd, 32'hAA00_FFDD);

        // Lone address or lone data must not be accepted
        @(negedge clk);
        bus.awaddr = 4'h0; bus.wdata = 32'h1234; bus.wstrb = 4'hF; bus.awvalid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("aw_only_awready", bus.awready, 0);
            check("aw_only_wready", bus.wready, 0);
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("w_only_awready", bus.awready, 0);
            check("w_only_wready", bus.wready, 0);
        end
        check("lone_bvalid", bus.bvalid, 0);
        bus.wvalid = 1'b0;
        $display("lone channel attempts done");
        axi_read(4'h0, rd); check("lone_unchanged", rd, 32'hAA00_FFDD);

        // Simultaneous read and write of BLANK returns the old value
        @(negedge clk);
        bus.awaddr = 4'hC; bus.wdata = 32'h0; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        bus.araddr = 4'hC; bus.arvalid = 1'b1; bus.rready = 1'b0;
        @(negedge clk);
        check("rw_awready", bus.awready, 1);
        check("rw_arready", bus.arready, 1);
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        @(negedge clk);
        check("rw_bvalid", bus.bvalid, 1);
        check("rw_rvalid", bus.rvalid, 1);
        check("rw_old_value", bus.rdata, 32'h4);
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
        $display("same-cycle read/write on BLANK");
        axi_read(4'hC, rd); check("rw_new_value", rd, 32'h0);

        // Response backpressure with a second write queued
        @(negedge clk);
        bus.bready = 1'b0;
        bus.awaddr = 4'h0; bus.wdata = 32'h4321; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        t = 0;
        while (!bus.awready && t < 20) begin @(negedge clk); t++; end
        check("bp_first_accept", bus.awready, 1);
        @(posedge clk); #1;
        bus.awaddr = 4'h4; bus.wdata = 32'h100;
        repeat (10) begin
            @(negedge clk);
            check("bp_bvalid_held", bus.bvalid, 1);
            check("bp_awready_low", bus.awready, 0);
            check("bp_wready_low", bus.wready, 0);
        end
        bus.bready = 1'b1;
        t = 0;
        @(negedge clk);
        while (!bus.awready && t < 20) begin @(negedge clk); t++; end
        check("bp_second_accept", bus.awready, 1);
        check("bp_bvalid_cleared", bus.bvalid, 0);
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        t = 0;
        @(negedge clk);
        while (!bus.bvalid && t < 20) begin @(negedge clk); t++; end
        check("bp_second_bvalid", bus.bvalid, 1);
        $display("backpressured writes done");
        axi_read(4'h0, rd); check("bp_digits", rd, 32'h4321);
        axi_read(4'h4, rd); check("bp_ctrl", rd, 32'h100);

        // Scan with PRESCALE=3: four clocks per digit
        exp_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
        exp_seg = '{7'h79, 7'h24, 7'h30, 7'h19};
        exp_dp  = '{1'b1, 1'b1, 1'b1, 1'b1};
        wait_slot_start(4'hE);
        scan_round(4);

        // Blank digit 2, decimal points on digits 0 and 1
        axi_write(4'h4, 32'h103, 4'hF);
        axi_write(4'hC, 32'h4, 4'hF);
        exp_an  = '{4'hE, 4'hD, 4'hF, 4'h7};
        exp_dp  = '{1'b0, 1'b0, 1'b1, 1'b1};
        wait_slot_start(4'hE);
        scan_round(4);

        // PRESCALE=0 advances every clock
        axi_write(4'hC, 32'h0, 4'hF);
        axi_write(4'h8, 32'h0, 4'hF);
        exp_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
        wait_slot_start(4'hE);
        scan_round(1);

        // Display disabled: all anodes off
        axi_write(4'h4, 32'h0, 4'hF);
        repeat (8) begin
            @(negedge clk);
            check("disabled_an", an, 4'hF);
        end
        $display("disabled display checked");

        // Reset while a read response is pending
        axi_write(4'h4, 32'h100, 4'hF);
        @(negedge clk);
        bus.araddr = 4'h0; bus.arvalid = 1'b1; bus.rready = 1'b0;
        t = 0;
        while (!bus.arready && t < 20) begin @(negedge clk); t++; end
        check("rr_arready", bus.arready, 1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        @(negedge clk);
        check("rr_rvalid_pending", bus.rvalid, 1);
        check("rr_rdata_pending", bus.rdata, 32'h4321);
        check("rr_an_active", an != 4'hF, 1);
        srst = 1'b1;
        @(negedge clk);
        check("rr_rvalid_dropped", bus.rvalid, 0);
        check("rr_rdata_zero", bus.rdata, 0);
        check("rr_an_off", an, 4'hF);
        check("rr_seg_off", seg, 7'h7F);
        check("rr_dp_off", dp, 1);
        srst = 1'b0;
        $display("reset during pending read");
        repeat (3) begin
            @(negedge clk);
            check("rr_no_late_rvalid", bus.rvalid, 0);
            check("rr_an_after", an, 4'hF);
        end
        axi_read(4'h0, rd); check("rr_digits_zero", rd, 32'h0);
        axi_read(4'h4, rd); check("rr_ctrl_zero", rd, 32'h0);
        axi_read(4'h8, rd); check("rr_prescale_zero", rd, 32'h0);
        axi_read(4'hC, rd); check("rr_blank_zero", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
